// File: rtl/byter_serializer.sv
// Word-to-byte serializer: captures a DATA_W-bit word when idle and enabled,
// then streams it out as DATA_W/8 registered bytes on consecutive cycles.
module byter_serializer #(
  parameter int unsigned DATA_W    = 64,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  output logic [7:0]        byte_out,
  output logic              data_ready
);

  localparam int unsigned N_BYTES = DATA_W / 8;
  localparam int unsigned CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [7:0]          byte_q;
  logic                ready_q;

  logic [7:0]          head_byte;
  logic [DATA_W-1:0]   shreg_adv;
  logic                last_byte;

  // Byte at the output end of the shift register and the register after it leaves.
  always_comb begin
    head_byte = 8'h00;
    shreg_adv = '0;
    if (LSB_FIRST) begin
      head_byte = shreg_q[7:0];
      shreg_adv = shreg_q >> 8;
    end else begin
      head_byte = shreg_q[DATA_W-1 -: 8];
      shreg_adv = shreg_q << 8;
    end
  end

  assign last_byte = (cnt_q == CNT_W'(N_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      byte_q  <= 8'h00;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          byte_q  <= 8'h00;
          ready_q <= 1'b0;
          if (enable) begin
            shreg_q <= data_in;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // One byte per edge; enable and data_in are ignored until the word ends.
          byte_q  <= head_byte;
          ready_q <= 1'b1;
          shreg_q <= shreg_adv;
          if (last_byte) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          byte_q  <= 8'h00;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_out   = byte_q;
  assign data_ready = ready_q;

endmodule

// File: tb/tb_byter_serializer.sv
// Bench for byter_serializer: two instances (LSB-first and MSB-first) share stimulus;
// expected bytes are computed arithmetically from the captured word.
module tb_byter_serializer;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned N_BYTES = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [DATA_W-1:0] data_in;
  logic [7:0]        byte_lsb;
  logic              ready_lsb;
  logic [7:0]        byte_msb;
  logic              ready_msb;

  int n_assert;
  int n_fail;

  byter_serializer #(.DATA_W(DATA_W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .data_in    (data_in),
    .byte_out   (byte_lsb),
    .data_ready (ready_lsb)
  );

  byter_serializer #(.DATA_W(DATA_W), .LSB_FIRST(1'b0)) dut_msb (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .data_in    (data_in),
    .byte_out   (byte_msb),
    .data_ready (ready_msb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_byte(input logic [DATA_W-1:0] w, input int k, input bit lsb);
    int idx;
    idx = lsb ? k : (N_BYTES - 1 - k);
    return 8'((w >> (8 * idx)) & 64'hFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Both instances must show an empty output (ready=0, byte=0).
  task automatic chk_idle(input string tag);
    chk({tag, "_rdy_lsb"},  8'(ready_lsb), 8'h00);
    chk({tag, "_byte_lsb"}, byte_lsb,      8'h00);
    chk({tag, "_rdy_msb"},  8'(ready_msb), 8'h00);
    chk({tag, "_byte_msb"}, byte_msb,      8'h00);
  endtask

  // Capture edge: the word is latched but no byte is produced.
  task automatic capture(input logic [DATA_W-1:0] w);
    enable  = 1'b1;
    data_in = w;
    tick();
    chk_idle("capture");
  endtask

  // N byte cycles; at cycle disturb_at enable drops and data_in goes to zero.
  task automatic expect_bytes(input logic [DATA_W-1:0] w, input string tag, input int disturb_at);
    for (int k = 0; k < N_BYTES; k++) begin
      if (k == disturb_at) begin
        enable  = 1'b0;
        data_in = '0;
      end
      tick();
      chk($sformatf("%s_rdy_lsb%0d", tag, k),  8'(ready_lsb), 8'h01);
      chk($sformatf("%s_byte_lsb%0d", tag, k), byte_lsb, ref_byte(w, k, 1'b1));
      chk($sformatf("%s_rdy_msb%0d", tag, k),  8'(ready_msb), 8'h01);
      chk($sformatf("%s_byte_msb%0d", tag, k), byte_msb, ref_byte(w, k, 1'b0));
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    enable = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_idle(tag);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] wa;
    logic [DATA_W-1:0] wb;
    int gap;
    n_assert = 0;
    n_fail   = 0;

    // Reset held two cycles with enable and all-ones data: nothing may be captured.
    rst     = 1'b1;
    enable  = 1'b1;
    data_in = '1;
    tick();
    chk_idle("reset0");
    tick();
    chk_idle("reset1");
    rst = 1'b0;
    idle_cycles(3, "post_reset");

    // Single word, with the characteristic byte pattern.
    w = 64'h0123_4567_89AB_CDEF;
    capture(w);
    enable = 1'b0;
    expect_bytes(w, "single", -1);
    idle_cycles(1, "single_done");
    chk("single_known_lsb0", ref_byte(w, 0, 1'b1), 8'hEF);
    chk("single_known_msb0", ref_byte(w, 0, 1'b0), 8'h01);

    // Continuous enable: one dead cycle between back-to-back words.
    wa = 64'd958923234673456104;
    wb = 64'd95892349073456104;
    capture(wa);
    expect_bytes(wa, "cont_a", -1);
    capture(wb);
    expect_bytes(wb, "cont_b", -1);
    enable = 1'b0;
    idle_cycles(2, "cont_done");

    // enable dropped and data zeroed two cycles after capture: word still completes.
    w = 64'h1122_3344_5566_7788;
    capture(w);
    expect_bytes(w, "drop", 1);
    idle_cycles(4, "drop_done");

    // Reset after the 4th byte discards the rest of the word.
    w = 64'hDEAD_BEEF_CAFE_F00D;
    capture(w);
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("midrst_byte_lsb%0d", k), byte_lsb, ref_byte(w, k, 1'b1));
      chk($sformatf("midrst_byte_msb%0d", k), byte_msb, ref_byte(w, k, 1'b0));
    end
    rst = 1'b1;
    tick();
    chk_idle("midrst_reset");
    rst = 1'b0;
    idle_cycles(2, "midrst_after");
    w = 64'h0F1E_2D3C_4B5A_6978;
    capture(w);
    enable = 1'b0;
    expect_bytes(w, "midrst_new", -1);
    idle_cycles(1, "midrst_new_done");

    // Randomized words with random idle gaps and random enable behaviour.
    for (int r = 0; r < 8; r++) begin
      w = {$urandom, $urandom};
      capture(w);
      if ($urandom_range(0, 1) == 0) enable = 1'b0;
      expect_bytes(w, $sformatf("rand%0d", r), int'($urandom_range(0, 9)));
      enable  = 1'b0;
      data_in = {$urandom, $urandom};
      gap = int'($urandom_range(1, 3));
      idle_cycles(gap, $sformatf("rand%0d_gap", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
